mem_port_arbiter: RTL and testbench

Shares the single memory port of the multi-cycle DLX datapath between instruction fetch and load/store data access. It arbitrates, latches the winner's operands, drives the port until the memory handshakes, and returns read data with a done pulse. It also rejects misaligned accesses and aborts on a memory timeout. It sits between the fetch/LSU stages and the memory model.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the DLX memory port between instruction fetch and load/store; data wins ties.
// Define ARB_FAIR_EN to let a starved fetch win a tie after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DATA, ERR} state_t;

    state_t         state_q;
    logic           owner_q;  // 1: data port owns the transaction
    logic [TW-1:0]  wait_q;
    logic [SW-1:0]  starve_q;
    logic           if_gnt_q, if_done_q, d_gnt_q, d_done_q, bus_err_q;
    logic           mem_en_q, mem_wr_q;
    logic [1:0]     mem_size_q;
    logic [31:0]    mem_addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;

    logic           fetch_first, sel_data, sel_fetch, win_mis, expire;
    logic [1:0]     win_size;
    logic [31:0]    win_addr;

`ifdef ARB_FAIR_EN
    assign fetch_first = (starve_q == SW'(STARVE_MAX));
`else
    assign fetch_first = 1'b0;
`endif

    always_comb begin
        sel_data  = d_req && !(if_req && fetch_first);
        sel_fetch = if_req && !sel_data;
        win_size  = sel_data ? d_size : 2'b10;
        win_addr  = sel_data ? d_addr : if_addr;
        win_mis   = (win_size == 2'b11) ||
                    (win_size == 2'b01 && win_addr[0]) ||
                    (win_size == 2'b10 && win_addr[1:0] != 2'b00);
        expire    = (TIMEOUT > 0) && (wait_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            wait_q      <= '0;
            starve_q    <= '0;
            if_gnt_q    <= 1'b0;
            if_done_q   <= 1'b0;
            d_gnt_q     <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_gnt_q  <= 1'b0;
            d_gnt_q   <= 1'b0;
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_data || sel_fetch) begin
                        owner_q     <= sel_data;
                        wait_q      <= '0;
                        if_gnt_q    <= sel_fetch;
                        d_gnt_q     <= sel_data;
                        mem_size_q  <= win_size;
                        mem_addr_q  <= win_addr;
                        mem_wr_q    <= sel_data && d_wr && !win_mis;
                        mem_wdata_q <= sel_data ? d_wdata : 32'h0;
                        if (sel_fetch)
                            starve_q <= '0;
                        else if (if_req && starve_q != SW'(STARVE_MAX))
                            starve_q <= starve_q + SW'(1);
                        if (win_mis) begin
                            state_q <= ERR;
                        end else begin
                            state_q  <= sel_data ? DATA : FETCH;
                            mem_en_q <= 1'b1;
                        end
                    end
                end
                FETCH, DATA: begin
                    // A ready on the timeout edge still completes normally.
                    if (mem_ready || expire) begin
                        state_q   <= IDLE;
                        mem_en_q  <= 1'b0;
                        mem_wr_q  <= 1'b0;
                        bus_err_q <= !mem_ready;
                        if (owner_q) d_done_q  <= 1'b1;
                        else         if_done_q <= 1'b1;
                        if (mem_ready && !owner_q)
                            if_rdata_q <= mem_rdata;
                        else if (mem_ready && !mem_wr_q)
                            d_rdata_q <= mem_rdata;
                    end else if (TIMEOUT > 0) begin
                        wait_q <= wait_q + TW'(1);
                    end
                end
                ERR: begin
                    state_q   <= IDLE;
                    bus_err_q <= 1'b1;
                    if (owner_q) d_done_q  <= 1'b1;
                    else         if_done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus hand-computed literal checks. Follows ARB_FAIR_EN like the design.
module tb_mem_port_arbiter;
    localparam int TIMEOUT    = 16;
    localparam int STARVE_MAX = 4;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0, mem_ready = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        if_gnt, if_done, d_gnt, d_done, bus_err, mem_en, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .bus_err(bus_err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
        int unsigned bytes;
        if (size == 2'b11) return 1'b1;
        bytes = 1 << size;
        return (addr % bytes) != 0;
    endfunction

    // Transaction-level model: one open transaction at a time, described by who owns it,
    // whether it was rejected, and how long it has waited.
    bit          act, own_d, bad, m_fetch;
    int          waited, starve;
    bit          e_if_gnt, e_if_done, e_d_gnt, e_d_done, e_err, e_mem_en, e_mem_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act = 0; own_d = 0; bad = 0; waited = 0; starve = 0;
            e_if_gnt = 0; e_if_done = 0; e_d_gnt = 0; e_d_done = 0; e_err = 0;
            e_mem_en = 0; e_mem_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
            e_if_rdata = 0; e_d_rdata = 0;
        end else begin
            e_if_gnt = 0; e_d_gnt = 0; e_if_done = 0; e_d_done = 0; e_err = 0;
            if (!act) begin
                if (d_req || if_req) begin
                    m_fetch = if_req && (!d_req || (FAIR && starve == STARVE_MAX));
                    if (m_fetch) begin
                        starve = 0;
                        e_size = 2'b10; e_addr = if_addr; e_mem_wr = 0;
                    end else begin
                        if (if_req && starve < STARVE_MAX) starve++;
                        e_size = d_size; e_addr = d_addr; e_mem_wr = d_wr; e_wdata = d_wdata;
                    end
                    own_d = !m_fetch;
                    bad = is_bad(e_size, e_addr);
                    act = 1; waited = 0;
                    e_mem_en = !bad;
                    e_if_gnt = m_fetch; e_d_gnt = !m_fetch;
                end
            end else if (bad || mem_ready || (TIMEOUT > 0 && waited + 1 >= TIMEOUT)) begin
                e_err = bad || !mem_ready;
                if (!bad && mem_ready) begin
                    if (!own_d) e_if_rdata = mem_rdata;
                    else if (!e_mem_wr) e_d_rdata = mem_rdata;
                end
                if (own_d) e_d_done = 1; else e_if_done = 1;
                act = 0; e_mem_en = 0;
            end else begin
                waited++;
            end
        end
    end

    always @(negedge clk) begin
        chk("if_gnt", if_gnt, e_if_gnt);
        chk("d_gnt", d_gnt, e_d_gnt);
        chk("if_done", if_done, e_if_done);
        chk("d_done", d_done, e_d_done);
        chk("bus_err", bus_err, e_err);
        chk("mem_en", mem_en, e_mem_en);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        if (e_mem_en) begin
            chk("mem_wr", mem_wr, e_mem_wr);
            chk("mem_size", mem_size, e_size);
            chk("mem_addr", mem_addr, e_addr);
            if (e_mem_wr) chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    int en_cnt, dg, fg;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        tick();

        // lone fetch, ready on the third busy cycle
        if_req = 1; if_addr = 32'h100;
        tick();
        chk("lf_gnt", if_gnt, 1); chk("lf_en", mem_en, 1);
        chk("lf_addr", mem_addr, 32'h100); chk("lf_size", mem_size, 2'b10); chk("lf_wr", mem_wr, 0);
        tick(); tick();
        mem_ready = 1; mem_rdata = 32'h20010005;
        tick();
        chk("lf_done", if_done, 1); chk("lf_rdata", if_rdata, 32'h20010005);
        chk("lf_err", bus_err, 0); chk("lf_en_off", mem_en, 0);
        if_req = 0; mem_ready = 0;
        tick();

        // tie: store first, fetch after one idle cycle
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_wr = 1; d_addr = 32'h200; d_size = 2'b10; d_wdata = 32'hCAFEF00D;
        tick();
        chk("tie_dgnt", d_gnt, 1); chk("tie_ignt", if_gnt, 0);
        chk("tie_wr", mem_wr, 1); chk("tie_wdata", mem_wdata, 32'hCAFEF00D);
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("tie_ddone", d_done, 1); chk("tie_drdata", d_rdata, 0); chk("tie_idle", mem_en, 0);
        d_req = 0; d_wr = 0; mem_ready = 0;
        tick();
        chk("tie_fgnt", if_gnt, 1); chk("tie_faddr", mem_addr, 32'h104);
        mem_ready = 1; mem_rdata = 32'h11112222;
        tick();
        chk("tie_fdone", if_done, 1); chk("tie_frdata", if_rdata, 32'h11112222);
        if_req = 0; mem_ready = 0;
        tick();

        // misaligned half
        d_req = 1; d_size = 2'b01; d_addr = 32'h203;
        tick();
        chk("mis_gnt", d_gnt, 1); chk("mis_en", mem_en, 0);
        tick();
        chk("mis_done", d_done, 1); chk("mis_err", bus_err, 1); chk("mis_en2", mem_en, 0);
        d_req = 0;
        tick();

        // size 11 is illegal
        d_req = 1; d_size = 2'b11; d_addr = 32'h0;
        tick(); tick();
        chk("sz3_err", bus_err, 1); chk("sz3_done", d_done, 1);
        d_req = 0;
        tick();

        // misaligned fetch
        if_req = 1; if_addr = 32'h102;
        tick(); tick();
        chk("fmis_done", if_done, 1); chk("fmis_err", bus_err, 1); chk("fmis_rdata", if_rdata, 32'h11112222);
        if_req = 0;
        tick();

        // aligned half load
        d_req = 1; d_size = 2'b01; d_addr = 32'h202;
        tick();
        chk("hl_en", mem_en, 1); chk("hl_size", mem_size, 2'b01);
        mem_ready = 1; mem_rdata = 32'h0000BEEF;
        tick();
        chk("hl_done", d_done, 1); chk("hl_err", bus_err, 0); chk("hl_rdata", d_rdata, 32'h0000BEEF);
        d_req = 0; mem_ready = 0;
        tick();

        // timeout: 16 busy cycles then abort
        d_req = 1; d_size = 2'b10; d_addr = 32'h300;
        tick();
        en_cnt = mem_en ? 1 : 0;
        repeat (15) begin
            tick();
            if (mem_en) en_cnt++;
        end
        chk("to_en_cycles", en_cnt, 16);
        tick();
        chk("to_done", d_done, 1); chk("to_err", bus_err, 1);
        chk("to_en_off", mem_en, 0); chk("to_rdata", d_rdata, 32'h0000BEEF);
        d_req = 0;
        tick();

        // ready on the 16th busy edge wins over the timeout
        d_req = 1;
        tick();
        repeat (15) tick();
        mem_ready = 1; mem_rdata = 32'h5A5A0001;
        tick();
        chk("tr_done", d_done, 1); chk("tr_err", bus_err, 0); chk("tr_rdata", d_rdata, 32'h5A5A0001);
        d_req = 0; mem_ready = 0;
        tick();

        // reset mid-fetch
        if_req = 1; if_addr = 32'h400;
        tick(); tick();
        rst_n = 0;
        #1;
        chk("rm_en", mem_en, 0); chk("rm_ifrdata", if_rdata, 0);
        chk("rm_drdata", d_rdata, 0); chk("rm_done", if_done, 0);
        if_req = 0;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1;
        tick(); tick();
        chk("rm_nodone", if_done, 0);
        if_req = 1; if_addr = 32'h500;
        tick();
        chk("rm_gnt", if_gnt, 1); chk("rm_addr", mem_addr, 32'h500);
        mem_ready = 1; mem_rdata = 32'h0BADCAFE;
        tick();
        chk("rm_done2", if_done, 1); chk("rm_rdata", if_rdata, 32'h0BADCAFE);
        if_req = 0; mem_ready = 0;
        tick();

        // both requesters held, memory always ready
        d_req = 1; if_req = 1; d_wr = 0; d_size = 2'b10; d_addr = 32'h600; if_addr = 32'h700;
        mem_ready = 1; mem_rdata = 32'h77;
        dg = 0; fg = 0;
        repeat (20) begin
            tick();
            if (d_gnt) dg++;
            if (if_gnt) fg++;
        end
        chk("fair_dgnts", dg, FAIR ? 8 : 10);
        chk("fair_fgnts", fg, FAIR ? 2 : 0);
        d_req = 0; if_req = 0; mem_ready = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
